// File: rtl/resonator_dds_div_pkg.sv
// Shared widths, states and saturation limits for the resonator DDS
// sequential signed divider.
package resonator_dds_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int QUOT_W     = 16;
    localparam int ITER       = 32;
    localparam int CNT_W      = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam logic signed [QUOT_W-1:0] QMAX = 16'sh7FFF;
    localparam logic signed [QUOT_W-1:0] QMIN = 16'sh8000;

endpackage

// File: rtl/resonator_dds_udiv_step.sv
// One radix-2 restoring step on magnitudes: shift in the next dividend
// bit, subtract the divisor when it fits, and report the quotient bit.
module resonator_dds_udiv_step
    import resonator_dds_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   i_prem,
    input  logic [DIVISOR_W-1:0] i_dvs,
    input  logic                 i_bit,
    output logic [DIVISOR_W:0]   o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0] w_sh;

    assign w_sh = {i_prem[DIVISOR_W-1:0], i_bit};

    // The top bit is only ever set when the divisor is zero.
    assign o_qbit = i_prem[DIVISOR_W] | (w_sh >= {1'b0, i_dvs});

    assign o_prem = o_qbit ? (w_sh - {1'b0, i_dvs}) : w_sh;

endmodule

// File: rtl/resonator_dds_sdiv_32s_16s_16_seq.sv
// Sequential 32s/16s signed divider with start/done handshake, ce stall
// and a fixed 34-cycle latency; quotient saturates to 16 bits.
module resonator_dds_sdiv_32s_16s_16_seq
    import resonator_dds_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [dout_WIDTH-1:0] rem,
    output logic                  done,
    output logic                  busy,
    output logic                  ovf
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIVIDEND_W-1:0]   r_dvd;
    logic [DIVIDEND_W-1:0]   r_quo;
    logic [DIVISOR_W:0]      r_prem;
    logic [DIVISOR_W-1:0]    r_dvs;
    logic                    r_sn;
    logic                    r_sq;
    logic                    r_dz;
    logic [CNT_W-1:0]        r_cnt;
    logic [QUOT_W-1:0]       r_dout;
    logic [QUOT_W-1:0]       r_rem;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_ovf;

    logic [DIVIDEND_W-1:0]   w_abs0;
    logic [DIVISOR_W-1:0]    w_abs1;
    logic [DIVISOR_W:0]      w_prem_nxt;
    logic                    w_qbit;
    logic [QUOT_W-1:0]       w_q;
    logic [QUOT_W-1:0]       w_r;
    logic                    w_ovf;

    // Two's-complement negate as unsigned: -2^31 lands on 2^31 exactly.
    assign w_abs0 = din0[DIVIDEND_W-1] ? (32'd0 - din0) : din0;
    assign w_abs1 = din1[DIVISOR_W-1]  ? (16'd0 - din1) : din1;

    resonator_dds_udiv_step u_step (
        .i_prem (r_prem),
        .i_dvs  (r_dvs),
        .i_bit  (r_dvd[DIVIDEND_W-1]),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = CALC;
            CALC: if (r_cnt == '0) w_state_nxt = FIX;
            FIX:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_q   = r_quo[QUOT_W-1:0];
        w_r   = r_sn ? (16'd0 - r_prem[DIVISOR_W-1:0])
                     : r_prem[DIVISOR_W-1:0];
        w_ovf = 1'b0;
        if (r_dz) begin
            w_q   = r_sn ? QMIN : QMAX;
            w_r   = '0;
            w_ovf = 1'b1;
        end else if (!r_sq && (r_quo > 32'd32767)) begin
            w_q   = QMAX;
            w_ovf = 1'b1;
        end else if (r_sq && (r_quo > 32'd32768)) begin
            w_q   = QMIN;
            w_ovf = 1'b1;
        end else if (r_sq) begin
            w_q = 16'd0 - r_quo[QUOT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd  <= '0;
            r_quo  <= '0;
            r_prem <= '0;
            r_dvs  <= '0;
            r_sn   <= 1'b0;
            r_sq   <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (ce) begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd  <= w_abs0;
                        r_dvs  <= w_abs1;
                        r_quo  <= '0;
                        r_prem <= '0;
                        r_sn   <= din0[DIVIDEND_W-1];
                        r_sq   <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                        r_dz   <= (din1 == '0);
                        r_cnt  <= CNT_W'(ITER - 1);
                        r_busy <= 1'b1;
                    end
                end
                CALC: begin
                    r_prem <= w_prem_nxt;
                    r_dvd  <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
                    r_quo  <= {r_quo[DIVIDEND_W-2:0], w_qbit};
                    r_cnt  <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_dout <= w_q;
                    r_rem  <= w_r;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dout = r_dout;
    assign rem  = r_rem;
    assign done = r_done;
    assign busy = r_busy;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_resonator_dds_sdiv_32s_16s_16_seq.sv
// Directed self-checking bench for the sequential signed divider.
module tb_resonator_dds_sdiv_32s_16s_16_seq;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               ce = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        din0 = '0;
    logic [15:0]        din1 = '0;
    logic signed [15:0] dout;
    logic signed [15:0] rem;
    logic               done;
    logic               busy;
    logic               ovf;

    int n_cmp = 0;
    int n_bad = 0;

    resonator_dds_sdiv_32s_16s_16_seq #(
        .ID(1), .din0_WIDTH(32), .din1_WIDTH(16), .dout_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .dout(dout), .rem(rem),
        .done(done), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Launch one division and count ce-high edges (accept edge included)
    // until done is seen; 999 means it never came.
    task automatic do_div(input logic [31:0] a, input logic [15:0] b,
                          input bit tog, output int n, output bit bsy_ok);
        int k;
        bsy_ok = 1'b1;
        @(negedge clk);
        din0 = a; din1 = b; start = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        n = 1; start = 1'b0; k = 0;
        while (done !== 1'b1 && k < 300) begin
            if (busy !== 1'b1) bsy_ok = 1'b0;
            @(negedge clk);
            ce = tog ? ~ce : 1'b1;
            @(posedge clk); #1;
            if (ce) n++;
            k++;
        end
        if (done !== 1'b1) n = 999;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0; start = 1'b1;
        din0 = 32'd100; din1 = 16'd7;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dout !== 16'sd0) begin n_bad++; $display("FAIL rst_dout got %0d want 0", dout); end
        n_cmp++; if (rem !== 16'sd0) begin n_bad++; $display("FAIL rst_rem got %0d want 0", rem); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", ovf); end
        @(negedge clk);
        start = 1'b0; reset = 1'b0; ce = 1'b1;
    endtask

    task automatic test_basic();
        int n; bit bok;
        do_div(32'd100, 16'd7, 1'b0, n, bok);
        n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL basic_lat got %0d want 34", n); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", bok); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        n_cmp++; if (dout !== 16'sd14) begin n_bad++; $display("FAIL basic_dout got %0d want 14", dout); end
        n_cmp++; if (rem !== 16'sd2) begin n_bad++; $display("FAIL basic_rem got %0d want 2", rem); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", ovf); end
    endtask

    task automatic test_signs();
        logic [31:0]        ta [4];
        logic [15:0]        tb [4];
        logic signed [15:0] tq [4];
        logic signed [15:0] tr [4];
        int n; bit bok;
        ta = '{32'd100, -32'sd100, 32'd100, -32'sd100};
        tb = '{16'd7, 16'd7, -16'sd7, -16'sd7};
        tq = '{16'sd14, -16'sd14, -16'sd14, 16'sd14};
        tr = '{16'sd2, -16'sd2, 16'sd2, -16'sd2};
        for (int i = 0; i < 4; i++) begin
            do_div(ta[i], tb[i], 1'b0, n, bok);
            n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL sign%0d_lat got %0d want 34", i, n); end
            n_cmp++; if (dout !== tq[i]) begin n_bad++; $display("FAIL sign%0d_dout got %0d want %0d", i, dout, tq[i]); end
            n_cmp++; if (rem !== tr[i]) begin n_bad++; $display("FAIL sign%0d_rem got %0d want %0d", i, rem, tr[i]); end
            n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sign%0d_ovf got %b want 0", i, ovf); end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0]        ta [3];
        logic signed [15:0] tq [3];
        int n; bit bok;
        ta = '{32'd7, -32'sd7, 32'd0};
        tq = '{16'sh7FFF, 16'sh8000, 16'sh7FFF};
        for (int i = 0; i < 3; i++) begin
            do_div(ta[i], 16'd0, 1'b0, n, bok);
            n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL dz%0d_lat got %0d want 34", i, n); end
            n_cmp++; if (dout !== tq[i]) begin n_bad++; $display("FAIL dz%0d_dout got %0d want %0d", i, dout, tq[i]); end
            n_cmp++; if (rem !== 16'sd0) begin n_bad++; $display("FAIL dz%0d_rem got %0d want 0", i, rem); end
            n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL dz%0d_ovf got %b want 1", i, ovf); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0]        ta [5];
        logic [15:0]        tb [5];
        logic signed [15:0] tq [5];
        logic signed [15:0] tr [5];
        logic               to [5];
        int n; bit bok;
        ta = '{32'h8000_0000, 32'd1000000, -32'sd65538, 32'd65534, 32'd65536};
        tb = '{16'hFFFF, 16'd3, 16'd2, 16'd2, 16'd2};
        tq = '{16'sh7FFF, 16'sh7FFF, 16'sh8000, 16'sh7FFF, 16'sh7FFF};
        tr = '{16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0};
        to = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_div(ta[i], tb[i], 1'b0, n, bok);
            n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL sat%0d_lat got %0d want 34", i, n); end
            n_cmp++; if (dout !== tq[i]) begin n_bad++; $display("FAIL sat%0d_dout got %0d want %0d", i, dout, tq[i]); end
            n_cmp++; if (rem !== tr[i]) begin n_bad++; $display("FAIL sat%0d_rem got %0d want %0d", i, rem, tr[i]); end
            n_cmp++; if (ovf !== to[i]) begin n_bad++; $display("FAIL sat%0d_ovf got %b want %b", i, ovf, to[i]); end
        end
    endtask

    task automatic test_ce_stall();
        int n; bit bok;
        do_div(32'd100, 16'd7, 1'b1, n, bok);
        n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL ce_lat got %0d want 34", n); end
        n_cmp++; if (dout !== 16'sd14) begin n_bad++; $display("FAIL ce_dout got %0d want 14", dout); end
        n_cmp++; if (rem !== 16'sd2) begin n_bad++; $display("FAIL ce_rem got %0d want 2", rem); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ce_ovf got %b want 0", ovf); end
        @(negedge clk); ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ce_hold%0d got %b want 1", i, done); end
        end
        @(negedge clk); ce = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ce_release got %b want 0", done); end
    endtask

    task automatic test_start_while_busy();
        int n; int k;
        @(negedge clk);
        din0 = 32'd100; din1 = 16'd7; start = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        n = 1; start = 1'b0; k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(negedge clk);
            start = (k == 4);
            if (k == 4) begin din0 = 32'd50; din1 = 16'd5; end
            @(posedge clk); #1;
            n++; k++;
        end
        if (done !== 1'b1) n = 999;
        n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL sbusy_lat got %0d want 34", n); end
        n_cmp++; if (dout !== 16'sd14) begin n_bad++; $display("FAIL sbusy_dout got %0d want 14", dout); end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sbusy_after got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int t1; int t2; int nd; int k;
        t1 = -1; t2 = -1; nd = 0; k = 0;
        @(negedge clk);
        din0 = 32'd100; din1 = 16'd7; start = 1'b1; ce = 1'b1;
        while (nd < 2 && k < 200) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (nd == 0) t1 = k; else t2 = k;
                nd++;
            end
            k++;
        end
        @(negedge clk); start = 1'b0;
        n_cmp++; if (t1 !== 33) begin n_bad++; $display("FAIL b2b_first got %0d want 33", t1); end
        n_cmp++; if (t2 !== 67) begin n_bad++; $display("FAIL b2b_second got %0d want 67", t2); end
        n_cmp++; if (dout !== 16'sd14) begin n_bad++; $display("FAIL b2b_dout got %0d want 14", dout); end
    endtask

    task automatic test_abort();
        int n; bit bok; bit seen;
        @(negedge clk);
        din0 = 32'd1000000; din1 = 16'd3; start = 1'b1; ce = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dout !== 16'sd0) begin n_bad++; $display("FAIL abort_dout got %0d want 0", dout); end
        n_cmp++; if (rem !== 16'sd0) begin n_bad++; $display("FAIL abort_rem got %0d want 0", rem); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL abort_ovf got %b want 0", ovf); end
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_quiet got %b want 0", seen); end
        do_div(32'hFFFF_8000, 16'h8000, 1'b0, n, bok);
        n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL post_lat got %0d want 34", n); end
        n_cmp++; if (dout !== 16'sd1) begin n_bad++; $display("FAIL post_dout got %0d want 1", dout); end
        n_cmp++; if (rem !== 16'sd0) begin n_bad++; $display("FAIL post_rem got %0d want 0", rem); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL post_ovf got %b want 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_saturation();
        test_ce_stall();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
